// File: rtl/vgacon_term_pkg.sv
// vgacon_pkg: shared constants, ASCII codes, state enum and row-address helper for the text terminal
package vgacon_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 50;
  localparam int SCREEN_CHARS = 4000;
  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [5:0] Y_MAX = 6'(ROWS - 1);
  localparam logic [12:0] LINE_LEN = 13'(COLS);
  localparam logic [12:0] SCREEN_LEN = 13'(SCREEN_CHARS);
  localparam logic [7:0] TAB_LIMIT = 8'(COLS);
  localparam logic [6:0] CR = 7'h0D;
  localparam logic [6:0] LF = 7'h0A;
  localparam logic [6:0] BS = 7'h08;
  localparam logic [6:0] TAB = 7'h09;
  localparam logic [6:0] FF = 7'h0C;
  localparam logic [7:0] BLANK = 8'h20;
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_e;
  function automatic logic [12:0] row_base(input logic [5:0] y);
    return ({7'd0, y} << 6) + ({7'd0, y} << 4);
  endfunction
endpackage

// File: rtl/vgacon_term_if.sv
// vgacon_term_if: byte-stream input handshake plus text-RAM write port and cursor/busy status
// master = byte source / observer, slave = vgacon_term
interface vgacon_term_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [12:0] tram_addr;
  logic [7:0] tram_data;
  logic tram_wren;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;
  logic busy;
  modport master (output in_data, in_valid, input in_ready, tram_addr, tram_data, tram_wren, cursor_x, cursor_y, busy);
  modport slave (input in_data, in_valid, output in_ready, tram_addr, tram_data, tram_wren, cursor_x, cursor_y, busy);
endinterface

// File: rtl/vgacon_term_fill.sv
// vgacon_term_fill: sequential BLANK address generator, one write per cycle from base_i for count_i cycles
// ports: clk, resetn, start_i/base_i/count_i (load), wren_o/addr_o/data_o (current write), done_o (last write cycle)
module vgacon_term_fill
  import vgacon_pkg::*;
#(parameter bit INIT_ACTIVE = 1'b1)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [12:0] base_i,
  input  logic [12:0] count_i,
  output logic        wren_o,
  output logic [12:0] addr_o,
  output logic [7:0]  data_o,
  output logic        done_o
);
  logic active_q, active_d;
  logic [12:0] addr_q, addr_d, rem_q, rem_d;
  // out of reset the generator may already be running a full-screen clear
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      active_q <= INIT_ACTIVE;
      addr_q <= 13'd0;
      rem_q <= SCREEN_LEN;
    end else begin
      active_q <= active_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
    end
  always_comb begin
    active_d = start_i | (active_q & (rem_q != 13'd1));
    addr_d = start_i ? base_i : active_q ? addr_q + 13'd1 : addr_q;
    rem_d = start_i ? count_i : active_q ? rem_q - 13'd1 : rem_q;
  end
  assign wren_o = active_q;
  assign addr_o = addr_q;
  assign data_o = BLANK;
  assign done_o = active_q & (rem_q == 13'd1);
endmodule

// File: rtl/vgacon_term.sv
// vgacon_term: byte-stream terminal front end driving text-RAM writes with cursor, control codes, wrap and clears
// ports: clk, resetn (async, active-low), bus (slave: in_data/in_valid/in_ready, tram_addr/data/wren, cursor_x/y, busy)
module vgacon_term
  import vgacon_pkg::*;
#(parameter bit CLEAR_ON_RESET = 1'b1)
(
  input logic clk,
  input logic resetn,
  vgacon_term_if.slave bus
);
  state_e state_q, state_d;
  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic ready_q, ready_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic wren_q, wren_d;
  logic fill_start, fill_wren, fill_done;
  logic [12:0] fill_base, fill_count, fill_addr;
  logic [7:0] fill_data;
  logic [6:0] c;
  logic [7:0] tab_x;
  logic accept, ctl, printable, is_cr, is_lf, is_bs, is_tab, is_ff, nl;
  assign c = bus.in_data[6:0];
  assign ctl = ~bus.in_data[7];
  assign accept = bus.in_valid & ready_q;
  assign printable = (c >= 7'h20) & (c <= 7'h7E);
  assign is_cr = ctl & (c == CR);
  assign is_lf = ctl & (c == LF);
  assign is_bs = ctl & (c == BS);
  assign is_tab = ctl & (c == TAB);
  assign is_ff = ctl & (c == FF);
  assign tab_x = ({1'b0, x_q} | 8'd7) + 8'd1;
  // a printable byte in the last column writes first, then wraps like LF
  assign nl = is_lf | (is_tab & (tab_x >= TAB_LIMIT)) | (printable & (x_q == X_MAX));
  vgacon_term_fill #(.INIT_ACTIVE(CLEAR_ON_RESET)) u_fill (
    .clk(clk),
    .resetn(resetn),
    .start_i(fill_start),
    .base_i(fill_base),
    .count_i(fill_count),
    .wren_o(fill_wren),
    .addr_o(fill_addr),
    .data_o(fill_data),
    .done_o(fill_done)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = !accept ? IDLE : is_ff ? CLR_ALL : nl ? CLR_LINE : IDLE;
    else if (fill_done)
      state_d = IDLE;
  end
  // ready reopens one cycle after the FSM returns, once the last blank write is on the bus
  always_comb begin
    ready_d = (state_q == IDLE) & (state_d == IDLE);
    x_d = x_q;
    y_d = y_q;
    fill_start = 1'b0;
    fill_base = 13'd0;
    fill_count = LINE_LEN;
    if (accept) begin
      if (is_ff) begin
        x_d = 7'd0;
        y_d = 6'd0;
        fill_start = 1'b1;
        fill_count = SCREEN_LEN;
      end else if (nl) begin
        x_d = 7'd0;
        y_d = (y_q == Y_MAX) ? 6'd0 : y_q + 6'd1;
        fill_start = 1'b1;
        fill_base = row_base(y_d);
      end else if (printable) x_d = x_q + 7'd1;
      else if (is_cr) x_d = 7'd0;
      else if (is_bs) x_d = (x_q != 7'd0) ? x_q - 7'd1 : x_q;
      else if (is_tab) x_d = tab_x[6:0];
    end
    wren_d = (state_q != IDLE) ? fill_wren : accept & printable;
    addr_d = (state_q != IDLE) ? fill_addr : (accept & printable) ? row_base(y_q) + {6'd0, x_q} : addr_q;
    data_d = (state_q != IDLE) ? fill_data : (accept & printable) ? bus.in_data : data_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      x_q <= 7'd0;
      y_q <= 6'd0;
      ready_q <= !CLEAR_ON_RESET;
      wren_q <= 1'b0;
      addr_q <= 13'd0;
      data_q <= 8'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      ready_q <= ready_d;
      wren_q <= wren_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign bus.in_ready = ready_q;
  assign bus.busy = ~ready_q;
  assign bus.tram_wren = wren_q;
  assign bus.tram_addr = addr_q;
  assign bus.tram_data = data_q;
  assign bus.cursor_x = x_q;
  assign bus.cursor_y = y_q;
endmodule

// File: tb/tb_vgacon_term.sv
// tb_vgacon_term: table-driven check of the terminal front end plus reset-clear, back-to-back and abort sequences
module tb_vgacon_term;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  vgacon_term_if bus();
  vgacon_term #(.CLEAR_ON_RESET(1'b1)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int errors = 0;
  int checks = 0;
  int wa[$];
  int wd[$];
  always @(negedge clk)
    if (bus.tram_wren) begin
      wa.push_back(int'(bus.tram_addr));
      wd.push_back(int'(bus.tram_data));
    end
  typedef struct {
    logic [7:0] din;
    int ex, ey, nw, a0, d0, al;
  } vec_t;
  vec_t tbl[44];
  function automatic vec_t v(input logic [7:0] din, input int ex, input int ey, input int nw, input int a0, input int d0, input int al);
    vec_t r;
    r.din = din; r.ex = ex; r.ey = ey; r.nw = nw; r.a0 = a0; r.d0 = d0; r.al = al;
    return r;
  endfunction
  function automatic int qa(input int i);
    return (i < wa.size()) ? wa[i] : -1;
  endfunction
  function automatic int qd(input int i);
    return (i < wd.size()) ? wd[i] : -1;
  endfunction
  function automatic int fill_ok();
    for (int i = 1; i < wa.size(); i++)
      if (wa[i] != wa[i-1] + 1 || wd[i] != 32 || wa[i] >= 4000) return 0;
    return 1;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask
  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus.in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ready_within_budget", int'(bus.in_ready), 1);
  endtask
  task automatic send(input logic [7:0] b);
    wait_ready(6000);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic settle();
    wait_ready(6000);
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic run_vec(input int i);
    wa.delete();
    wd.delete();
    send(tbl[i].din);
    settle();
    chk($sformatf("v%0d_x", i), int'(bus.cursor_x), tbl[i].ex);
    chk($sformatf("v%0d_y", i), int'(bus.cursor_y), tbl[i].ey);
    chk($sformatf("v%0d_nwrites", i), wa.size(), tbl[i].nw);
    if (tbl[i].nw > 0) begin
      chk($sformatf("v%0d_first_addr", i), qa(0), tbl[i].a0);
      chk($sformatf("v%0d_first_data", i), qd(0), tbl[i].d0);
      chk($sformatf("v%0d_last_addr", i), qa(wa.size() - 1), tbl[i].al);
      chk($sformatf("v%0d_blank_fill", i), fill_ok(), 1);
    end
  endtask
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec(i);
  endtask
  task automatic send_lfs(input int n);
    for (int i = 0; i < n; i++) begin
      wa.delete();
      wd.delete();
      send(8'h0A);
      settle();
    end
  endtask
  task automatic check_full_clear(input string tag);
    chk({tag, "_count"}, wa.size(), 4000);
    chk({tag, "_first"}, qa(0), 0);
    chk({tag, "_last"}, qa(3999), 3999);
    chk({tag, "_fill"}, fill_ok(), 1);
    chk({tag, "_data0"}, qd(0), 32);
    chk({tag, "_cx"}, int'(bus.cursor_x), 0);
    chk({tag, "_cy"}, int'(bus.cursor_y), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask
  initial begin
    int n;
    tbl[0] = v(8'h0A, 0, 1, 80, 80, 32, 159);
    tbl[1] = v(8'h0A, 0, 2, 80, 160, 32, 239);
    tbl[2] = v(8'h0A, 0, 3, 80, 240, 32, 319);
    for (int k = 0; k < 9; k++) tbl[3+k] = v(8'h09, 8*(k+1), 3, 0, 0, 0, 0);
    tbl[12] = v(8'h61, 73, 3, 1, 312, 8'h61, 312);
    tbl[13] = v(8'h62, 74, 3, 1, 313, 8'h62, 313);
    tbl[14] = v(8'h63, 75, 3, 1, 314, 8'h63, 314);
    tbl[15] = v(8'hE4, 76, 3, 1, 315, 8'hE4, 315);
    tbl[16] = v(8'h7E, 77, 3, 1, 316, 8'h7E, 316);
    tbl[17] = v(8'h20, 78, 3, 1, 317, 8'h20, 317);
    tbl[18] = v(8'h21, 79, 3, 1, 318, 8'h21, 318);
    tbl[19] = v(8'h5A, 0, 4, 81, 319, 8'h5A, 399);
    tbl[20] = v(8'h8D, 0, 4, 0, 0, 0, 0);
    tbl[21] = v(8'h01, 0, 4, 0, 0, 0, 0);
    tbl[22] = v(8'h7F, 0, 4, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) tbl[23+k] = v(8'h09, 8*(k+1), 49, 0, 0, 0, 0);
    tbl[32] = v(8'h09, 0, 0, 80, 0, 32, 79);
    tbl[33] = v(8'h0A, 0, 0, 80, 0, 32, 79);
    for (int k = 0; k < 5; k++) tbl[34+k] = v(8'(8'h68 + k), k + 1, 0, 1, k, 8'h68 + k, k);
    tbl[39] = v(8'h09, 8, 0, 0, 0, 0, 0);
    tbl[40] = v(8'h08, 7, 0, 0, 0, 0, 0);
    tbl[41] = v(8'h0D, 0, 0, 0, 0, 0, 0);
    tbl[42] = v(8'h08, 0, 0, 0, 0, 0, 0);
    tbl[43] = v(8'h51, 1, 0, 1, 0, 8'h51, 0);
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wren", int'(bus.tram_wren), 0);
    chk("rst_addr", int'(bus.tram_addr), 0);
    chk("rst_data", int'(bus.tram_data), 0);
    chk("rst_cx", int'(bus.cursor_x), 0);
    chk("rst_cy", int'(bus.cursor_y), 0);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(bus.busy), 1);
    wa.delete();
    wd.delete();
    resetn = 1'b1;
    settle();
    check_full_clear("boot_clear");
    wa.delete();
    wd.delete();
    wait_ready(10);
    bus.in_data = 8'h41;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 chk("b2b_ready_after_first", int'(bus.in_ready), 1);
    bus.in_data = 8'hC2;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("b2b_ready_after_second", int'(bus.in_ready), 1);
    settle();
    chk("b2b_nwrites", wa.size(), 2);
    chk("b2b_addr0", qa(0), 0);
    chk("b2b_data0", qd(0), 8'h41);
    chk("b2b_addr1", qa(1), 1);
    chk("b2b_data1", qd(1), 8'hC2);
    chk("b2b_cx", int'(bus.cursor_x), 2);
    chk("b2b_cy", int'(bus.cursor_y), 0);
    run_range(0, 22);
    send_lfs(45);
    chk("lf_walk_y", int'(bus.cursor_y), 49);
    run_range(23, 32);
    send_lfs(49);
    chk("lf_walk2_y", int'(bus.cursor_y), 49);
    run_range(33, 43);
    wa.delete();
    wd.delete();
    send(8'h0C);
    @(negedge clk);
    chk("ff_cx", int'(bus.cursor_x), 0);
    chk("ff_cy", int'(bus.cursor_y), 0);
    chk("ff_busy", int'(bus.busy), 1);
    n = 0;
    while (wa.size() < 100 && n < 500) begin
      @(negedge clk);
      #1 n++;
    end
    chk("ff_pre_count", wa.size(), 100);
    chk("ff_pre_first", qa(0), 0);
    chk("ff_pre_last", qa(99), 99);
    #1 resetn = 1'b0;
    #1 chk("abort_wren", int'(bus.tram_wren), 0);
    chk("abort_addr", int'(bus.tram_addr), 0);
    chk("abort_ready", int'(bus.in_ready), 0);
    n = wa.size();
    repeat (3) @(negedge clk);
    #1 chk("abort_no_writes", wa.size(), n);
    wa.delete();
    wd.delete();
    resetn = 1'b1;
    settle();
    check_full_clear("restart_clear");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
